snoop_bus_ctrl: RTL and testbench

//  Two-CPU snooping coherence bus controller sitting directly downstream of each cpu's coherence port.

---
 rtl/snoop_bus_ctrl_pkg.sv | 36 +++
 rtl/snoop_bus_ctrl_arb.sv | 26 ++
 rtl/snoop_bus_ctrl.sv | 141 ++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types and defaults for the two-CPU MSI snooping bus controller.
package snoop_bus_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF        = 11;
    localparam int unsigned SNOOP_TIMEOUT_DEF = 4;
    localparam int unsigned N_CPU             = 2;

    typedef enum logic [1:0] {
        BLK_I = 2'b00,
        BLK_S = 2'b01,
        BLK_M = 2'b10
    } blk_state_t;

    typedef enum logic [1:0] {
        REQ_RM,
        REQ_WM,
        REQ_INV
    } bus_req_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SNOOP,
        BUS_GRANT
    } bus_state_t;

    // Per-cpu request type: write_miss beats read_miss beats invalidate.
    function automatic bus_req_t req_type(input logic rm, input logic wm, input logic inv);
        bus_req_t t;
        t = REQ_INV;
        if (wm)       t = REQ_WM;
        else if (rm)  t = REQ_RM;
        else if (inv) t = REQ_INV;
        return t;
    endfunction

endpackage

// File: rtl/snoop_bus_ctrl_arb.sv
// Two-input round-robin arbiter; last_gnt starts at 1 so cpu0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       pick_c
);

    logic last_gnt_q;

    // Remember the most recently served requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last_gnt_q <= 1'b1;
        else if (upd) last_gnt_q <= upd_idx;
    end

    // Single request wins outright; a tie goes to the cpu not served last.
    always_comb begin
        pick_c = 1'b0;
        if (req == 2'b10)      pick_c = 1'b1;
        else if (req == 2'b11) pick_c = ~last_gnt_q;
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Two-CPU snooping coherence bus controller: arbitrate, snoop the peer, grant, invalidate.
module snoop_bus_ctrl
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned SNOOP_TIMEOUT = SNOOP_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             read_miss,
    input  logic [1:0]             write_miss,
    input  logic [1:0]             invalidate,
    input  logic [1:0][ADDR_W-1:0] BICO,
    input  logic [1:0][1:0]        block_state,
    input  logic [1:0]             cpu_search_found,
    output logic [1:0]             grant,
    output logic [1:0]             cpu_search,
    output logic [1:0][ADDR_W-1:0] BOCI,
    output logic [1:0]             cpu_datasel,
    output logic [1:0]             invalidate_from_other_cpu,
    output logic                   bus_busy
);

    localparam int unsigned CNT_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

    bus_state_t        state_q, state_n;
    logic              r_q, r_n;
    bus_req_t          type_q, type_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              found_q, found_n;
    logic              peer_mod_q, peer_mod_n;
    logic              first_q, first_n;

    logic [1:0]        req;
    logic              pick_c;
    logic              arb_upd;
    logic              o_idx;

    assign req   = read_miss | write_miss | invalidate;
    assign o_idx = ~r_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .upd     (arb_upd),
        .upd_idx (r_q),
        .pick_c  (pick_c)
    );

    // State and transaction latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUS_IDLE;
            r_q        <= 1'b0;
            type_q     <= REQ_RM;
            addr_q     <= '0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            peer_mod_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            r_q        <= r_n;
            type_q     <= type_n;
            addr_q     <= addr_n;
            cnt_q      <= cnt_n;
            found_q    <= found_n;
            peer_mod_q <= peer_mod_n;
            first_q    <= first_n;
        end
    end

    // Next-state logic plus output decode from state and latches.
    always_comb begin
        state_n    = state_q;
        r_n        = r_q;
        type_n     = type_q;
        addr_n     = addr_q;
        cnt_n      = cnt_q;
        found_n    = found_q;
        peer_mod_n = peer_mod_q;
        first_n    = 1'b0;
        arb_upd    = 1'b0;

        grant                     = '0;
        cpu_search                = '0;
        BOCI                      = '0;
        cpu_datasel               = '0;
        invalidate_from_other_cpu = '0;
        bus_busy                  = (state_q != BUS_IDLE);

        case (state_q)
            BUS_IDLE: begin
                if (|req) begin
                    state_n = BUS_SNOOP;
                    r_n     = pick_c;
                    type_n  = req_type(read_miss[pick_c], write_miss[pick_c], invalidate[pick_c]);
                    addr_n  = BICO[pick_c];
                    cnt_n   = '0;
                end
            end
            BUS_SNOOP: begin
                cpu_search[o_idx] = 1'b1;
                BOCI[o_idx]       = addr_q;
                if (!req[r_q]) begin
                    state_n = BUS_IDLE;
                    cnt_n   = '0;
                end else if (cpu_search_found[o_idx]) begin
                    state_n    = BUS_GRANT;
                    found_n    = 1'b1;
                    peer_mod_n = (block_state[o_idx] == BLK_M);
                    first_n    = 1'b1;
                end else if (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                    state_n    = BUS_GRANT;
                    found_n    = 1'b0;
                    peer_mod_n = 1'b0;
                    first_n    = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            BUS_GRANT: begin
                grant[r_q]       = 1'b1;
                cpu_datasel[r_q] = found_q & peer_mod_q & (type_q != REQ_INV);
                invalidate_from_other_cpu[o_idx] =
                    first_q & found_q & ((type_q == REQ_WM) || (type_q == REQ_INV));
                if (!req[r_q]) begin
                    state_n = BUS_IDLE;
                    cnt_n   = '0;
                    arb_upd = 1'b1;
                end
            end
            default: begin
                state_n = BUS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed self-checking bench for snoop_bus_ctrl.
module tb_snoop_bus_ctrl;

    localparam int unsigned ADDR_W = 11;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             read_miss;
    logic [1:0]             write_miss;
    logic [1:0]             invalidate;
    logic [1:0][ADDR_W-1:0] BICO;
    logic [1:0][1:0]        block_state;
    logic [1:0]             cpu_search_found;
    logic [1:0]             grant;
    logic [1:0]             cpu_search;
    logic [1:0][ADDR_W-1:0] BOCI;
    logic [1:0]             cpu_datasel;
    logic [1:0]             invalidate_from_other_cpu;
    logic                   bus_busy;

    int tests;
    int fails;

    snoop_bus_ctrl #(.ADDR_W(ADDR_W), .SNOOP_TIMEOUT(4)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .read_miss                 (read_miss),
        .write_miss                (write_miss),
        .invalidate                (invalidate),
        .BICO                      (BICO),
        .block_state               (block_state),
        .cpu_search_found          (cpu_search_found),
        .grant                     (grant),
        .cpu_search                (cpu_search),
        .BOCI                      (BOCI),
        .cpu_datasel               (cpu_datasel),
        .invalidate_from_other_cpu (invalidate_from_other_cpu),
        .bus_busy                  (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        read_miss        = 2'b00;
        write_miss       = 2'b00;
        invalidate       = 2'b00;
        cpu_search_found = 2'b00;
        block_state      = {2'b00, 2'b00};
    endtask

    task automatic test_reset();
        clear_inputs();
        BICO  = {11'h2AA, 11'h155};
        rst_n = 1'b0;
        #1;
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus_busy); end
        tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant got %b want 00", grant); end
        tests++; if (cpu_search !== 2'b00) begin fails++; $display("FAIL reset_search got %b want 00", cpu_search); end
        tests++; if (BOCI !== 22'h0) begin fails++; $display("FAIL reset_boci got %h want 0", BOCI); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL reset_idle got %b want 0", bus_busy); end
    endtask

    // cpu0 read miss, cpu1 holds the line modified: one snoop cycle, data from peer.
    task automatic test_read_peer_mod();
        BICO[0] = 11'h155; BICO[1] = 11'h2AA;
        read_miss = 2'b01; cpu_search_found = 2'b10; block_state[1] = 2'b10;
        tick();
        tests++; if (cpu_search !== 2'b10) begin fails++; $display("FAIL rpm_search got %b want 10", cpu_search); end
        tests++; if (BOCI[1] !== 11'h155) begin fails++; $display("FAIL rpm_boci1 got %h want 155", BOCI[1]); end
        tests++; if (BOCI[0] !== 11'h000) begin fails++; $display("FAIL rpm_boci0 got %h want 000", BOCI[0]); end
        tests++; if (bus_busy !== 1'b1) begin fails++; $display("FAIL rpm_busy got %b want 1", bus_busy); end
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rpm_grant got %b want 01", grant); end
        tests++; if (cpu_datasel !== 2'b01) begin fails++; $display("FAIL rpm_datasel got %b want 01", cpu_datasel); end
        tests++; if (invalidate_from_other_cpu !== 2'b00) begin fails++; $display("FAIL rpm_inv got %b want 00", invalidate_from_other_cpu); end
        tests++; if (cpu_search !== 2'b00) begin fails++; $display("FAIL rpm_search_off got %b want 00", cpu_search); end
        clear_inputs();
        tick();
        tests++; if ({bus_busy, grant} !== 3'b000) begin fails++; $display("FAIL rpm_release got %b want 000", {bus_busy, grant}); end
    endtask

    // cpu1 read miss, cpu0 never answers: grant only after four snoop cycles.
    task automatic test_snoop_timeout();
        BICO[1] = 11'h0F3;
        read_miss = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if ({cpu_search, grant} !== 4'b0100) begin fails++; $display("FAIL to_snoop%0d got %b want 0100", k, {cpu_search, grant}); end
        end
        tests++; if (BOCI[0] !== 11'h0F3) begin fails++; $display("FAIL to_boci0 got %h want 0f3", BOCI[0]); end
        tick();
        tests++; if (grant !== 2'b10) begin fails++; $display("FAIL to_grant got %b want 10", grant); end
        tests++; if (cpu_datasel !== 2'b00) begin fails++; $display("FAIL to_datasel got %b want 00", cpu_datasel); end
        tests++; if (invalidate_from_other_cpu !== 2'b00) begin fails++; $display("FAIL to_inv got %b want 00", invalidate_from_other_cpu); end
        clear_inputs();
        tick();
    endtask

    // cpu0 write miss, cpu1 shared: one-cycle invalidate into cpu1.
    task automatic test_write_invalidate();
        BICO[0] = 11'h3C1;
        write_miss = 2'b01; cpu_search_found = 2'b10; block_state[1] = 2'b01;
        tick();
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL wi_grant got %b want 01", grant); end
        tests++; if (invalidate_from_other_cpu !== 2'b10) begin fails++; $display("FAIL wi_pulse got %b want 10", invalidate_from_other_cpu); end
        tests++; if (cpu_datasel !== 2'b00) begin fails++; $display("FAIL wi_datasel got %b want 00", cpu_datasel); end
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL wi_grant_hold got %b want 01", grant); end
        tests++; if (invalidate_from_other_cpu !== 2'b00) begin fails++; $display("FAIL wi_pulse_end got %b want 00", invalidate_from_other_cpu); end
        clear_inputs();
        tick();
    endtask

    // Simultaneous requests from reset: cpu0 first, then alternate on ties.
    task automatic test_back_to_back();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        clear_inputs();
        read_miss = 2'b11; cpu_search_found = 2'b11;
        tick();
        tests++; if (cpu_search !== 2'b10) begin fails++; $display("FAIL bb_first_search got %b want 10", cpu_search); end
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL bb_first_grant got %b want 01", grant); end
        read_miss = 2'b10;
        tick();
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL bb_idle got %b want 0", bus_busy); end
        tick();
        tests++; if (cpu_search !== 2'b01) begin fails++; $display("FAIL bb_second_search got %b want 01", cpu_search); end
        tick();
        tests++; if (grant !== 2'b10) begin fails++; $display("FAIL bb_second_grant got %b want 10", grant); end
        read_miss = 2'b00;
        tick();
        read_miss = 2'b11;
        tick();
        tests++; if (cpu_search !== 2'b10) begin fails++; $display("FAIL bb_tie1_search got %b want 10", cpu_search); end
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL bb_tie1_grant got %b want 01", grant); end
        read_miss = 2'b00;
        tick();
        read_miss = 2'b11;
        tick();
        tests++; if (cpu_search !== 2'b01) begin fails++; $display("FAIL bb_tie2_search got %b want 01", cpu_search); end
        tick();
        tests++; if (grant !== 2'b10) begin fails++; $display("FAIL bb_tie2_grant got %b want 10", grant); end
        clear_inputs();
        tick();
    endtask

    // cpu1 invalidate together with write miss behaves as a write miss; then a snoop abort.
    task automatic test_type_and_abort();
        BICO[1] = 11'h07E;
        invalidate = 2'b10; write_miss = 2'b10;
        cpu_search_found = 2'b01; block_state[0] = 2'b10;
        tick();
        tick();
        tests++; if (grant !== 2'b10) begin fails++; $display("FAIL ta_grant got %b want 10", grant); end
        tests++; if (cpu_datasel !== 2'b10) begin fails++; $display("FAIL ta_datasel got %b want 10", cpu_datasel); end
        tests++; if (invalidate_from_other_cpu !== 2'b01) begin fails++; $display("FAIL ta_pulse got %b want 01", invalidate_from_other_cpu); end
        clear_inputs();
        tick();
        invalidate = 2'b10; write_miss = 2'b10;
        tick();
        tests++; if (cpu_search !== 2'b01) begin fails++; $display("FAIL ab_search got %b want 01", cpu_search); end
        clear_inputs();
        tick();
        tests++; if ({bus_busy, grant} !== 3'b000) begin fails++; $display("FAIL ab_idle got %b want 000", {bus_busy, grant}); end
        tick();
        tests++; if ({bus_busy, grant, cpu_search} !== 5'b00000) begin fails++; $display("FAIL ab_quiet got %b want 00000", {bus_busy, grant, cpu_search}); end
    endtask

    // Async reset during GRANT clears outputs immediately; bus accepts a new request afterwards.
    task automatic test_reset_mid_grant();
        BICO[0] = 11'h155;
        write_miss = 2'b01; cpu_search_found = 2'b10; block_state[1] = 2'b01;
        tick();
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rg_pre got %b want 01", grant); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({bus_busy, grant, invalidate_from_other_cpu, cpu_datasel} !== 7'b0) begin
            fails++; $display("FAIL rg_clear got %b want 0000000", {bus_busy, grant, invalidate_from_other_cpu, cpu_datasel}); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL rg_idle got %b want 0", bus_busy); end
        read_miss = 2'b01; cpu_search_found = 2'b10; block_state[1] = 2'b00;
        tick();
        tests++; if (cpu_search !== 2'b10) begin fails++; $display("FAIL rg_new_search got %b want 10", cpu_search); end
        tick();
        tests++; if ({grant, cpu_datasel} !== 4'b0100) begin fails++; $display("FAIL rg_new_grant got %b want 0100", {grant, cpu_datasel}); end
        clear_inputs();
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_read_peer_mod();
        test_snoop_timeout();
        test_write_invalidate();
        test_back_to_back();
        test_type_and_abort();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
